// File: rtl/bcd_conv_arbiter.sv
// Shared double-dabble binary-to-BCD converter with a two-client round-robin front end.
// One bit is converted per clock; the result is returned with the owning client's ID.
module bcd_conv_arbiter #(
  parameter int W      = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0_valid,
  input  logic [W-1:0]          req0_data,
  output logic                  req0_ready,
  input  logic                  req1_valid,
  input  logic [W-1:0]          req1_data,
  output logic                  req1_ready,
  output logic                  out_valid,
  output logic [4*DIGITS-1:0]   out_bcd,
  output logic                  out_id,
  input  logic                  out_ready,
  output logic                  busy
);

  localparam int CW = $clog2(W + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} stateT;

  stateT               state, stateNext;
  logic [W-1:0]        shReg;
  logic [4*DIGITS-1:0] bcd;
  logic [4*DIGITS-1:0] bcdAdj;
  logic [CW-1:0]       stepCnt;
  logic                idReg;
  logic                lastGrant;

  function automatic logic [4*DIGITS-1:0] add3(input logic [4*DIGITS-1:0] v);
    logic [4*DIGITS-1:0] r;
    r = v;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] >= 4'd5) r[4*i +: 4] = v[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  assign bcdAdj = add3(bcd);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= stateNext;
  end

  always_comb begin
    stateNext  = state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    case (state)
      IDLE: begin
        // lastGrant==1 means client 1 was served last, so client 0 wins a tie
        req0_ready = req0_valid & (~req1_valid | lastGrant);
        req1_ready = req1_valid & (~req0_valid | ~lastGrant);
        if (req0_ready || req1_ready) stateNext = SHIFT;
      end
      SHIFT: if (stepCnt == CW'(W - 1)) stateNext = DONE;
      DONE:  if (out_ready) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shReg     <= '0;
      bcd       <= '0;
      stepCnt   <= '0;
      idReg     <= 1'b0;
      lastGrant <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (req0_ready) begin
            shReg     <= req0_data;
            bcd       <= '0;
            stepCnt   <= '0;
            idReg     <= 1'b0;
            lastGrant <= 1'b0;
          end else if (req1_ready) begin
            shReg     <= req1_data;
            bcd       <= '0;
            stepCnt   <= '0;
            idReg     <= 1'b1;
            lastGrant <= 1'b1;
          end
        end
        SHIFT: begin
          bcd     <= {bcdAdj[4*DIGITS-2:0], shReg[W-1]};
          shReg   <= {shReg[W-2:0], 1'b0};
          stepCnt <= stepCnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign out_bcd   = bcd;
  assign out_id    = idReg;

endmodule

// File: tb/tb_bcd_conv_arbiter.sv
// Directed bench for bcd_conv_arbiter: timing, boundaries, arbitration, backpressure,
// mid-conversion reset and a full 0..255 sweep against a divide/modulo reference.
module tb_bcd_conv_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req1_valid;
  logic [7:0]  req0_data, req1_data;
  logic        req0_ready, req1_ready;
  logic        out_valid;
  logic [11:0] out_bcd;
  logic        out_id;
  logic        out_ready;
  logic        busy;

  int nTests = 0;
  int nFail  = 0;

  bcd_conv_arbiter #(.W(8), .DIGITS(3)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .out_valid(out_valid), .out_bcd(out_bcd), .out_id(out_id),
    .out_ready(out_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nTests++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] refBcd(input int v);
    logic [11:0] r;
    r[11:8] = 4'(v / 100);
    r[7:4]  = 4'((v / 10) % 10);
    r[3:0]  = 4'(v % 10);
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkReset(input string tag);
    checkVal({tag, "_valid"}, 32'(out_valid), 32'd0);
    checkVal({tag, "_bcd"},   32'(out_bcd),   32'd0);
    checkVal({tag, "_id"},    32'(out_id),    32'd0);
    checkVal({tag, "_busy"},  32'(busy),      32'd0);
  endtask

  // Issue one request from client id and collect its result; stall randomises out_ready.
  task automatic runOne(input int id, input int data, input bit stall, input string tag);
    int n;
    logic r;
    logic [11:0] exp;
    exp = refBcd(data);
    if (id == 0) begin req0_valid = 1'b1; req0_data = 8'(data); end
    else         begin req1_valid = 1'b1; req1_data = 8'(data); end
    #1;
    n = 0;
    while (!((id == 0) ? req0_ready : req1_ready) && n < 50) begin step(); n++; end
    checkVal({tag, "_grant"}, 32'((id == 0) ? req0_ready : req1_ready), 32'd1);
    step();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 50) begin
      out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      step();
      n++;
    end
    checkVal({tag, "_valid"}, 32'(out_valid), 32'd1);
    checkVal({tag, "_bcd"},   32'(out_bcd),   32'(exp));
    checkVal({tag, "_id"},    32'(out_id),    32'(id));
    n = 0;
    r = 1'b0;
    while (!r && n < 50) begin
      r = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      out_ready = r;
      step();
      n++;
      if (!r) checkVal({tag, "_hold"}, 32'(out_bcd), 32'(exp));
    end
    out_ready = 1'b1;
  endtask

  task automatic doReset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    int n;
    int pulses;
    logic [11:0] bnd[6];
    int bndIn[6];
    int ids[3];
    logic [11:0] exps[3];

    rst = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_data = '0; req1_data = '0;
    out_ready = 1'b1;
    doReset();
    checkReset("rst");
    checkVal("rst_rdy0", 32'(req0_ready), 32'd0);
    checkVal("rst_rdy1", 32'(req1_ready), 32'd0);

    // single conversion with exact cycle timing
    req0_valid = 1'b1; req0_data = 8'd255;
    #1;
    checkVal("single_rdy0", 32'(req0_ready), 32'd1);
    step();
    req0_valid = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      checkVal($sformatf("single_busy_c%0d", c), 32'(busy), 32'd1);
      checkVal($sformatf("single_valid_c%0d", c), 32'(out_valid), 32'(c == 9));
      if (c == 9) begin
        checkVal("single_bcd", 32'(out_bcd), 32'h255);
        checkVal("single_id",  32'(out_id),  32'd0);
      end
      step();
    end
    checkVal("single_idle_busy", 32'(busy), 32'd0);
    checkVal("single_idle_valid", 32'(out_valid), 32'd0);

    // boundary values with hand-computed BCD
    bndIn = '{0, 9, 10, 99, 100, 128};
    bnd   = '{12'h000, 12'h009, 12'h010, 12'h099, 12'h100, 12'h128};
    for (int i = 0; i < 6; i++) begin
      checkVal($sformatf("bnd_ref_%0d", bndIn[i]), 32'(refBcd(bndIn[i])), 32'(bnd[i]));
      runOne(0, bndIn[i], 1'b0, $sformatf("bnd_%0d", bndIn[i]));
    end

    // tie and round robin; reset restores client 0 priority
    doReset();
    req0_valid = 1'b1; req0_data = 8'd42;
    req1_valid = 1'b1; req1_data = 8'd7;
    ids  = '{0, 1, 0};
    exps = '{12'h042, 12'h007, 12'h042};
    for (int k = 0; k < 3; k++) begin
      n = 0;
      while (!out_valid && n < 50) begin step(); n++; end
      if (k == 2) begin req0_valid = 1'b0; req1_valid = 1'b0; end
      checkVal($sformatf("rr%0d_valid", k), 32'(out_valid), 32'd1);
      checkVal($sformatf("rr%0d_id", k),    32'(out_id),    32'(ids[k]));
      checkVal($sformatf("rr%0d_bcd", k),   32'(out_bcd),   32'(exps[k]));
      step();
    end

    // backpressure: result held, no new accept while DONE
    out_ready = 1'b0;
    req1_valid = 1'b1; req1_data = 8'd200;
    req0_valid = 1'b1; req0_data = 8'd11;
    n = 0;
    while (!out_valid && n < 50) begin step(); n++; end
    checkVal("bp_first_id", 32'(out_id), 32'd1);
    for (int c = 0; c < 5; c++) begin
      step();
      checkVal($sformatf("bp_valid_%0d", c), 32'(out_valid), 32'd1);
      checkVal($sformatf("bp_bcd_%0d", c),   32'(out_bcd),   32'h200);
      checkVal($sformatf("bp_id_%0d", c),    32'(out_id),    32'd1);
      checkVal($sformatf("bp_rdy_%0d", c),   32'({req0_ready, req1_ready}), 32'd0);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    out_ready = 1'b1;
    step();
    checkVal("bp_idle_busy", 32'(busy), 32'd0);

    // reset mid-SHIFT aborts the conversion
    runOne(1, 33, 1'b0, "pre_rst");
    req1_valid = 1'b1; req1_data = 8'd77;
    #1;
    checkVal("mrst_grant", 32'(req1_ready), 32'd1);
    step();
    req1_valid = 1'b0;
    repeat (3) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    checkReset("mrst");
    pulses = 0;
    for (int c = 0; c < 12; c++) begin
      if (out_valid) pulses++;
      step();
    end
    checkVal("mrst_no_pulse", 32'(pulses), 32'd0);
    req0_valid = 1'b1; req0_data = 8'd1;
    req1_valid = 1'b1; req1_data = 8'd2;
    #1;
    checkVal("mrst_tie_rdy0", 32'(req0_ready), 32'd1);
    checkVal("mrst_tie_rdy1", 32'(req1_ready), 32'd0);
    req1_valid = 1'b0;
    runOne(0, 1, 1'b0, "mrst_after");

    // exhaustive sweep, alternating clients, random out_ready stalls
    for (int v = 0; v < 256; v++) begin
      runOne(v % 2, v, 1'b1, $sformatf("sweep_%0d", v));
    end

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, %0d tests run", nTests);
    $fatal(1);
  end

endmodule
